// File: rtl/multi_alarm_if.sv
// Alarm-slot load bus for multi_alarm.
// Ports: ld_alarm strobe, ld_sel slot index, h_in1/h_in0/m_in1/m_in0 BCD hh:mm.
interface multi_alarm_if #(
  parameter int N_ALARM = 4
);
  localparam int SW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

  logic          ld_alarm;
  logic [SW-1:0] ld_sel;
  logic [1:0]    h_in1;
  logic [3:0]    h_in0;
  logic [3:0]    m_in1;
  logic [3:0]    m_in0;

  modport master (
    output ld_alarm, ld_sel,
    output h_in1, h_in0, m_in1, m_in0
  );

  modport slave (
    input ld_alarm, ld_sel,
    input h_in1, h_in0, m_in1, m_in0
  );
endinterface

// File: rtl/multi_alarm.sv
// Multi-slot alarm clock: N_ALARM hh:mm slots, ring with timeout, optional snooze.
// Ports: clk_1s/reset, cur_* BCD time, ld (slot load bus), al_en per-slot arm,
//   stop_al/snooze controls, alarm/ring_id/snoozing registered outputs.
// Build option: MULTI_ALARM_SNOOZE_EN adds the SNOOZE state and its counter.
module multi_alarm #(
  parameter int N_ALARM        = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  localparam int SW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk_1s,
  input  logic               reset,
  input  logic [1:0]         cur_h1,
  input  logic [3:0]         cur_h0,
  input  logic [3:0]         cur_m1,
  input  logic [3:0]         cur_m0,
  input  logic [3:0]         cur_s1,
  input  logic [3:0]         cur_s0,
  multi_alarm_if.slave       ld,
  input  logic [N_ALARM-1:0] al_en,
  input  logic               stop_al,
  input  logic               snooze,
  output logic               alarm,
  output logic [SW-1:0]      ring_id,
  output logic               snoozing
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RING = 2'd1;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam logic [1:0] S_SNZ  = 2'd2;
  localparam logic [11:0] SNZ_LD = 12'(SNOOZE_MIN * 60 - 1);
`endif
  localparam logic [7:0] RING_LD = 8'(RING_TIMEOUT_S);

  logic [13:0]        slot_q [N_ALARM];
  logic [13:0]        now_hm;
  logic               sec0;
  logic [N_ALARM-1:0] hit;
  logic               any_hit;
  logic [SW-1:0]      hit_id;
  logic               armed;
  logic [1:0]         state;
  logic [7:0]         ring_cnt;

  assign now_hm = {cur_h1, cur_h0, cur_m1, cur_m0};
  assign sec0   = (cur_s1 == 4'd0) && (cur_s0 == 4'd0);
  assign any_hit = |hit;
  assign armed  = al_en[ring_id];

  // Downward scan so the lowest matching slot wins.
  always_comb begin
    hit    = '0;
    hit_id = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      hit[i] = al_en[i] && sec0 && (slot_q[i] == now_hm);
      if (hit[i]) hit_id = SW'(i);
    end
  end

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ALARM; i++) slot_q[i] <= '0;
    end else if (ld.ld_alarm && (32'(ld.ld_sel) < N_ALARM)) begin
      slot_q[ld.ld_sel] <= {ld.h_in1, ld.h_in0, ld.m_in1, ld.m_in0};
    end
  end

`ifdef MULTI_ALARM_SNOOZE_EN
  logic [11:0] snz_cnt;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snoozing = 1'b0;
`endif

  // Matches are only sampled in IDLE, so a match on the edge that
  // returns to IDLE cannot retrigger.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ring_cnt <= '0;
      alarm    <= 1'b0;
      ring_id  <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
      snz_cnt  <= '0;
      snoozing <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (any_hit) begin
            state    <= S_RING;
            ring_id  <= hit_id;
            ring_cnt <= RING_LD;
            alarm    <= 1'b1;
          end
        end
        S_RING: begin
          if (stop_al || !armed) begin
            state    <= S_IDLE;
            ring_cnt <= '0;
            alarm    <= 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
          end else if (snooze) begin
            state    <= S_SNZ;
            ring_cnt <= '0;
            alarm    <= 1'b0;
            snoozing <= 1'b1;
            snz_cnt  <= SNZ_LD;
`endif
          end else if (ring_cnt <= 8'd1) begin
            state    <= S_IDLE;
            ring_cnt <= '0;
            alarm    <= 1'b0;
          end else begin
            ring_cnt <= ring_cnt - 8'd1;
          end
        end
`ifdef MULTI_ALARM_SNOOZE_EN
        S_SNZ: begin
          if (stop_al || !armed) begin
            state    <= S_IDLE;
            snoozing <= 1'b0;
            snz_cnt  <= '0;
          end else if (snz_cnt == 12'd0) begin
            state    <= S_RING;
            ring_cnt <= RING_LD;
            alarm    <= 1'b1;
            snoozing <= 1'b0;
          end else begin
            snz_cnt <= snz_cnt - 12'd1;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/multi_alarm.md
MULTI_ALARM -- requirements
Module: multi_alarm

Interface
REQ-001 Parameter N_ALARM, default 4, number of independent alarm slots (range 1..16).
REQ-002 Parameter SNOOZE_MIN, default 5, snooze duration in minutes (range 1..59).
REQ-003 Parameter RING_TIMEOUT_S, default 60, seconds of unattended ringing before auto-stop (range 1..255).
REQ-004 Port clk_1s  input  1  1 Hz time-base clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Ports cur_h1/cur_h0/cur_m1/cur_m0/cur_s1/cur_s0  input  2/4/4/4/4/4  current time of day, BCD digits.
REQ-007 Port ld_alarm  input  1  load alarm slot ld_sel from h_in1/h_in0/m_in1/m_in0.
REQ-008 Port ld_sel  input  max(1,$clog2(N_ALARM))  slot index for load.
REQ-009 Ports h_in1/h_in0/m_in1/m_in0  input  2/4/4/4  alarm time to load, BCD.
REQ-010 Port al_en  input  N_ALARM  per-slot enable, bit i arms slot i.
REQ-011 Port stop_al  input  1  stop ringing or cancel snooze.
REQ-012 Port snooze  input  1  request snooze while ringing.
REQ-013 Port alarm  output  1  high while ringing.
REQ-014 Port ring_id  output  max(1,$clog2(N_ALARM))  slot that caused the current ring/snooze.
REQ-015 Port snoozing  output  1  high while in SNOOZE state.

Function
REQ-016 Each slot SHALL store hour/minute digits (14 bits); ld_alarm=1 with ld_sel<N_ALARM writes that slot on the next edge; ld_sel>=N_ALARM is ignored; values are stored unchecked.
REQ-017 Slot i SHALL match when al_en[i]=1, stored hh:mm equals cur hh:mm, and cur_s1=cur_s0=0.
REQ-018 The FSM SHALL have states IDLE, RING, SNOOZE; all outputs registered.
REQ-019 IDLE: on an edge where any slot matches, go to RING, ring_id = lowest matching index, alarm=1 after that same edge (one-edge latency).
REQ-020 RING: load a ring counter with RING_TIMEOUT_S on entry, decrement per edge; at 0 return to IDLE.
REQ-021 RING: stop_al=1 -> IDLE; snooze=1 (stop_al=0) -> SNOOZE with snooze counter = SNOOZE_MIN*60-1 (12-bit).
REQ-022 SNOOZE: alarm=0, snoozing=1; counter decrements per edge; at 0 -> RING with same ring_id and fresh ring timeout.
REQ-023 SNOOZE: stop_al=1 -> IDLE immediately on that edge.
REQ-024 stop_al and snooze asserted together SHALL be treated as stop.
REQ-025 Matches of any slot while in RING or SNOOZE SHALL be ignored (not queued).
REQ-026 Clearing al_en[ring_id] in RING or SNOOZE SHALL return to IDLE on the next edge.
REQ-027 Loading slot ring_id during RING/SNOOZE SHALL update storage without affecting the current ring.
REQ-028 On return to IDLE, a match on the same edge SHALL NOT retrigger; re-arming requires a match on a later edge.

Reset
REQ-029 reset=1 SHALL asynchronously set all slots to 0:00, state IDLE, counters 0, alarm=0, snoozing=0, ring_id=0.
REQ-030 Reset mid-RING or mid-SNOOZE SHALL abort immediately; operation resumes at the first edge after release.

Configuration
REQ-031 Macro MULTI_ALARM_SNOOZE_EN: defined -> SNOOZE state and snooze counter present as above.
REQ-032 Without MULTI_ALARM_SNOOZE_EN: snooze input ignored, snoozing tied 0, SNOOZE state and counter not synthesised, RING exits only by stop_al, al_en clear, or timeout.

Verification
REQ-033 Load slot 2 = 07:30, al_en=4'b0100, cur 07:29:59 -> 07:30:00 -> alarm=1, ring_id=2 after the 07:30:00 edge.
REQ-034 Slots 1 and 3 both 06:00, both enabled, cur reaches 06:00:00 -> ring_id=1; slot 3 never rings.
REQ-035 Ringing, snooze=1 one edge -> alarm=0, snoozing=1; 300 edges later (SNOOZE_MIN=5) alarm=1 again, same ring_id.
REQ-036 Ringing, no input for 60 edges -> alarm=0, state IDLE; stop_al+snooze together while ringing -> IDLE, snoozing=0.
REQ-037 reset pulse mid-SNOOZE -> alarm=0, snoozing=0 immediately, all slots read 00:00 (no ring at 00:00:00 with al_en=0).
REQ-038 Build without MULTI_ALARM_SNOOZE_EN, snooze=1 while ringing -> alarm stays 1 until stop_al or timeout.
